fc_input_packer: RTL and testbench

- Upstream feeder for the fully connected layer.
- Accepts a serial valid/ready stream of feature values from the last pooling/flatten stage and packs INPUT_SIZE of them into the FC layer's packed data_in vector.
- Issues a one-cycle en pulse to the FC layer, then holds the vector stable until the FC layer reports data_valid.
- Provides optional ReLU, frame-length checking and a completion watchdog.

---
 rtl/fc_pkg.sv | 19 +
 rtl/fc_watchdog.sv | 42 ++++
 rtl/fc_input_packer.sv | 129 ++++++++++++
 tb/tb_fc_input_packer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared definitions for the FC input packer: FSM states and a width helper
// used for the beat counter and the completion watchdog.
package fc_pkg;

  typedef enum logic [1:0] {
    FILL = 2'd0,
    FIRE = 2'd1,
    WAIT = 2'd2
  } state_e;

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int clog2_min1(input int value);
    int width;
    width = 0;
    while ((1 << width) < value) width++;
    return (width < 1) ? 1 : width;
  endfunction

endpackage

// File: rtl/fc_watchdog.sv
// Completion watchdog: counts enabled cycles and flags expiry on the
// TIMEOUT-th one. A TIMEOUT of 0 removes the counter entirely.
module fc_watchdog
  import fc_pkg::*;
#(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  generate
    if (TIMEOUT == 0) begin : g_off
      logic unused_inputs;
      assign unused_inputs = ^{clk, rstn, clear_i, enable_i};
      assign expired_o     = 1'b0;
    end else begin : g_on
      localparam int W = clog2_min1(TIMEOUT);
      localparam logic [W-1:0] LIMIT = W'(TIMEOUT - 1);

      logic [W-1:0] count_q;

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          count_q <= '0;
        end else if (clear_i) begin
          count_q <= '0;
        end else if (enable_i && (count_q != LIMIT)) begin
          count_q <= count_q + 1'b1;
        end
      end

      // Expiry is seen during the TIMEOUT-th enabled cycle so the owner can
      // leave its wait state on that same edge.
      assign expired_o = enable_i && (count_q == LIMIT);
    end
  endgenerate

endmodule

// File: rtl/fc_input_packer.sv
// Packs a serial valid/ready feature stream into the FC layer's data_in
// vector, fires a one-cycle start pulse and holds the vector until done.
module fc_input_packer
  import fc_pkg::*;
#(
  parameter int INPUT_SIZE = 512,
  parameter int DATA_WIDTH = 8,
  parameter int RELU_EN    = 1,
  parameter int TIMEOUT    = 1024
) (
  input  logic                             clk,
  input  logic                             rstn,
  input  logic                             s_valid,
  output logic                             s_ready,
  input  logic [DATA_WIDTH-1:0]            s_data,
  input  logic                             s_last,
  output logic [INPUT_SIZE*DATA_WIDTH-1:0] fc_data_in,
  output logic                             fc_en,
  input  logic                             fc_done,
  output logic                             busy,
  output logic                             frame_err
);

  localparam int CNT_W = clog2_min1(INPUT_SIZE);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(INPUT_SIZE - 1);

  state_e                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] slot_q [INPUT_SIZE];
  logic                  fc_en_q, fc_en_d;
  logic                  frame_err_q, frame_err_d;
  logic                  busy_q;
  logic                  accept;
  logic                  wd_expired;
  logic [DATA_WIDTH-1:0] capture;

  // Held low while rstn is asserted even though the state already reads FILL.
  assign s_ready = rstn && (state_q == FILL);
  assign accept  = s_valid && s_ready;
  assign capture = ((RELU_EN != 0) && s_data[DATA_WIDTH-1]) ? '0 : s_data;

  fc_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk       (clk),
    .rstn      (rstn),
    .clear_i   (state_q != WAIT),
    .enable_i  (state_q == WAIT),
    .expired_o (wd_expired)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    fc_en_d     = 1'b0;
    frame_err_d = 1'b0;
    unique case (state_q)
      FILL: begin
        if (accept) begin
          if (cnt_q == LAST_IDX) begin
            state_d     = FIRE;
            fc_en_d     = 1'b1;
            frame_err_d = !s_last;
          end else if (s_last) begin
            cnt_d       = '0;
            frame_err_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      FIRE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A done arriving on the expiry cycle still counts as a clean finish.
        if (fc_done) begin
          state_d = FILL;
          cnt_d   = '0;
        end else if (wd_expired) begin
          state_d     = FILL;
          cnt_d       = '0;
          frame_err_d = 1'b1;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= FILL;
      cnt_q       <= '0;
      fc_en_q     <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      fc_en_q     <= fc_en_d;
      frame_err_q <= frame_err_d;
      busy_q      <= (state_d != FILL);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int j = 0; j < INPUT_SIZE; j++) slot_q[j] <= '0;
    end else begin
      for (int j = 0; j < INPUT_SIZE; j++) begin
        if (accept && (cnt_q == CNT_W'(j))) slot_q[j] <= capture;
      end
    end
  end

  generate
    for (genvar g = 0; g < INPUT_SIZE; g++) begin : g_pack
      assign fc_data_in[g*DATA_WIDTH +: DATA_WIDTH] = slot_q[g];
    end
  endgenerate

  assign fc_en     = fc_en_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_fc_input_packer.sv
// Bench for fc_input_packer: one ReLU and one pass-through instance share a
// stimulus stream and are compared against a frame-level reference model.
module tb_fc_input_packer;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int TO = 16;

  logic          clk     = 1'b0;
  logic          rstn    = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_last  = 1'b0;
  logic          fc_done = 1'b0;
  logic [DW-1:0] s_data  = '0;

  logic          rdyA, rdyB, enA, enB, busyA, busyB, errA, errB;
  logic [N*DW-1:0] dataA, dataB;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state: beats of the frame in progress and the slot
  // contents each instance should be showing.
  logic [DW-1:0] frameQ[$];
  logic [DW-1:0] expRelu [N];
  logic [DW-1:0] expRaw  [N];
  logic          expFire;
  logic          expErr;

  always #5 clk = ~clk;

  fc_input_packer #(
    .INPUT_SIZE (N), .DATA_WIDTH (DW), .RELU_EN (1), .TIMEOUT (TO)
  ) dutRelu (
    .clk (clk), .rstn (rstn), .s_valid (s_valid), .s_ready (rdyA),
    .s_data (s_data), .s_last (s_last), .fc_data_in (dataA), .fc_en (enA),
    .fc_done (fc_done), .busy (busyA), .frame_err (errA)
  );

  fc_input_packer #(
    .INPUT_SIZE (N), .DATA_WIDTH (DW), .RELU_EN (0), .TIMEOUT (TO)
  ) dutRaw (
    .clk (clk), .rstn (rstn), .s_valid (s_valid), .s_ready (rdyB),
    .s_data (s_data), .s_last (s_last), .fc_data_in (dataB), .fc_en (enB),
    .fc_done (fc_done), .busy (busyB), .frame_err (errB)
  );

  function automatic logic [DW-1:0] relu(input logic [DW-1:0] v);
    return ($signed(v) < 0) ? '0 : v;
  endfunction

  function automatic logic [N*DW-1:0] packRelu();
    logic [N*DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r = r | ((N*DW)'(expRelu[i]) << (i * DW));
    return r;
  endfunction

  function automatic logic [N*DW-1:0] packRaw();
    logic [N*DW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) r = r | ((N*DW)'(expRaw[i]) << (i * DW));
    return r;
  endfunction

  task automatic modelReset();
    frameQ.delete();
    for (int i = 0; i < N; i++) begin
      expRelu[i] = '0;
      expRaw[i]  = '0;
    end
    expFire = 1'b0;
    expErr  = 1'b0;
  endtask

  // Frame rules: a beat lands in the next slot; the N-th beat fires (and is
  // an error unless it carries last); an earlier last discards the frame.
  task automatic modelAccept(input logic [DW-1:0] value, input logic last);
    int slot;
    frameQ.push_back(value);
    slot          = frameQ.size() - 1;
    expRelu[slot] = relu(value);
    expRaw[slot]  = value;
    expFire       = 1'b0;
    expErr        = 1'b0;
    if (frameQ.size() == N) begin
      expFire = 1'b1;
      expErr  = !last;
      frameQ.delete();
    end else if (last) begin
      expErr = 1'b1;
      frameQ.delete();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    assert (observed === expected)
    else begin
      miscompares++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Presents one beat after an idle gap, waits (bounded) for the handshake,
  // then checks every output against the model right after the accept edge.
  task automatic applyStimulus(input logic [DW-1:0] value, input logic last,
                               input int gap);
    int waited;
    s_valid = 1'b0;
    s_last  = 1'b0;
    repeat (gap) tick();
    s_valid = 1'b1;
    s_data  = value;
    s_last  = last;
    waited  = 0;
    while (!rdyA && waited < 20) begin
      tick();
      waited++;
    end
    checkOutput("handshake ready", 64'(rdyA), 64'd1);
    tick();
    s_valid = 1'b0;
    s_last  = 1'b0;
    modelAccept(value, last);
    checkOutput("fc_en after beat", 64'({enA, enB}), 64'({2{expFire}}));
    checkOutput("frame_err after beat", 64'({errA, errB}), 64'({2{expErr}}));
    checkOutput("busy after beat", 64'({busyA, busyB}), 64'({2{expFire}}));
    checkOutput("s_ready after beat", 64'({rdyA, rdyB}), 64'({2{~expFire}}));
    checkOutput("vector relu", 64'(dataA), 64'(packRelu()));
    checkOutput("vector raw", 64'(dataB), 64'(packRaw()));
  endtask

  // Called in the FIRE cycle: checks the WAIT cycle, then returns done.
  task automatic releaseFrame(input int doneDelay);
    tick();
    checkOutput("fc_en width", 64'({enA, enB}), 64'd0);
    checkOutput("busy in wait", 64'({busyA, busyB}), 64'h3);
    checkOutput("s_ready in wait", 64'({rdyA, rdyB}), 64'd0);
    checkOutput("no err in wait", 64'({errA, errB}), 64'd0);
    repeat (doneDelay) tick();
    checkOutput("held vector relu", 64'(dataA), 64'(packRelu()));
    fc_done = 1'b1;
    tick();
    fc_done = 1'b0;
    checkOutput("busy after done", 64'({busyA, busyB}), 64'd0);
    checkOutput("s_ready after done", 64'({rdyA, rdyB}), 64'h3);
    checkOutput("no err after done", 64'({errA, errB}), 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global time limit reached");
    $fatal(1, "[TB] simulation did not complete");
  end

  initial begin
    int kind;
    int len;
    modelReset();

    // Reset with random inputs toggling.
    repeat (3) begin
      s_valid = 1'($urandom);
      s_last  = 1'($urandom);
      fc_done = 1'($urandom);
      s_data  = DW'($urandom);
      tick();
      checkOutput("reset fc_en", 64'({enA, enB}), 64'd0);
      checkOutput("reset busy", 64'({busyA, busyB}), 64'd0);
      checkOutput("reset frame_err", 64'({errA, errB}), 64'd0);
      checkOutput("reset vector", 64'({dataA, dataB}), 64'd0);
      checkOutput("reset s_ready", 64'({rdyA, rdyB}), 64'd0);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    fc_done = 1'b0;
    rstn    = 1'b1;
    #1;
    checkOutput("s_ready after release", 64'({rdyA, rdyB}), 64'h3);

    // Normal frame, back-to-back, done returned three cycles after accept.
    applyStimulus(8'h05, 1'b0, 0);
    applyStimulus(8'hF0, 1'b0, 0);
    applyStimulus(8'h7F, 1'b0, 0);
    applyStimulus(8'h80, 1'b1, 0);
    checkOutput("frame relu on", 64'(dataA), 64'h007F0005);
    checkOutput("frame relu off", 64'(dataB), 64'h807FF005);
    releaseFrame(1);

    // Same frame with two-cycle upstream stalls.
    applyStimulus(8'h05, 1'b0, 2);
    applyStimulus(8'hF0, 1'b0, 2);
    applyStimulus(8'h7F, 1'b0, 2);
    applyStimulus(8'h80, 1'b1, 2);
    checkOutput("stalled relu on", 64'(dataA), 64'h007F0005);
    checkOutput("stalled relu off", 64'(dataB), 64'h807FF005);
    releaseFrame(0);

    // Short frame, then a full frame.
    applyStimulus(DW'($urandom), 1'b0, 0);
    applyStimulus(DW'($urandom), 1'b1, 0);
    tick();
    checkOutput("short err single pulse", 64'({errA, errB}), 64'd0);
    checkOutput("short no fc_en", 64'({enA, enB}), 64'd0);
    for (int b = 0; b < N; b++) applyStimulus(DW'($urandom), b == N - 1, 0);
    releaseFrame(2);

    // Long frame; a done during FIRE must be ignored.
    for (int b = 0; b < N; b++) applyStimulus(DW'($urandom), 1'b0, 0);
    checkOutput("long err with fc_en", 64'({enA, errA}), 64'h3);
    fc_done = 1'b1;
    tick();
    fc_done = 1'b0;
    checkOutput("done in FIRE ignored", 64'({busyA, busyB}), 64'h3);
    checkOutput("long err single pulse", 64'({errA, errB}), 64'd0);
    fc_done = 1'b1;
    tick();
    fc_done = 1'b0;
    checkOutput("long frame released", 64'({busyA, rdyA}), 64'h1);

    // Randomised mix of normal, short and long frames.
    for (int f = 0; f < 8; f++) begin
      kind = $urandom_range(0, 2);
      len  = (kind == 1) ? $urandom_range(1, N - 1) : N;
      for (int b = 0; b < len; b++)
        applyStimulus(DW'($urandom), (b == len - 1) && (kind != 2), $urandom_range(0, 2));
      if (len == N) begin
        releaseFrame($urandom_range(0, 4));
      end else begin
        tick();
        checkOutput("random short err drop", 64'({errA, errB}), 64'd0);
      end
    end

    // Watchdog: no done at all.
    for (int b = 0; b < N; b++) applyStimulus(DW'($urandom), b == N - 1, 0);
    for (int i = 1; i <= TO; i++) begin
      tick();
      checkOutput("waiting for timeout", 64'({busyA, errA, busyB, errB}), 64'hA);
    end
    tick();
    checkOutput("timeout err", 64'({errA, errB}), 64'h3);
    checkOutput("timeout busy", 64'({busyA, busyB}), 64'd0);
    checkOutput("timeout s_ready", 64'({rdyA, rdyB}), 64'h3);
    tick();
    checkOutput("timeout err drop", 64'({errA, errB}), 64'd0);

    // Reset in the middle of filling the next frame.
    applyStimulus(DW'($urandom), 1'b0, 0);
    applyStimulus(DW'($urandom), 1'b0, 0);
    rstn = 1'b0;
    #1;
    checkOutput("mid reset vector", 64'({dataA, dataB}), 64'd0);
    checkOutput("mid reset s_ready", 64'({rdyA, rdyB}), 64'd0);
    modelReset();
    tick();
    rstn = 1'b1;
    #1;
    checkOutput("mid reset release", 64'({rdyA, rdyB}), 64'h3);
    for (int b = 0; b < N; b++) applyStimulus(DW'($urandom), b == N - 1, 0);
    releaseFrame(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
